// File: rtl/ten_bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flop, behind a start/busy/done handshake.
module ten_bit_serial_subtractor #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             br_reg, br_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic             ovf_reg, ovf_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    logic             bit_d;
    logic             bit_br;
    logic [WIDTH-1:0] res_shifted;

    assign bit_d       = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    assign bit_br      = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
    assign res_shifted = {bit_d, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            cnt_reg    <= '0;
            br_reg     <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_reg    <= res_next;
            cnt_reg    <= cnt_next;
            br_reg     <= br_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            ovf_reg    <= ovf_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_next    = res_reg;
        cnt_next    = cnt_reg;
        br_next     = br_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        ovf_next    = ovf_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    res_next   = '0;
                    cnt_next   = '0;
                    br_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                a_sh_next = a_sh_reg >> 1;
                b_sh_next = b_sh_reg >> 1;
                res_next  = res_shifted;
                br_next   = bit_br;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    // On the last bit the shift-register LSBs hold the original operand MSBs.
                    diff_next   = res_shifted;
                    borrow_next = bit_br;
                    ovf_next    = (a_sh_reg[0] ^ b_sh_reg[0]) & (a_sh_reg[0] ^ bit_d);
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;
    assign ovf        = ovf_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_ten_bit_serial_subtractor.sv
// Self-checking bench for ten_bit_serial_subtractor: directed cases, random operands against
// an arithmetic reference, busy-ignore, back-to-back and asynchronous-reset scenarios.
module tb_ten_bit_serial_subtractor;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    ten_bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from plain integer arithmetic.
    function automatic logic [W-1:0] m_diff(input int xa, input int xb);
        int r;
        r = (xa - xb + 1024) % 1024;
        return W'(r);
    endfunction

    function automatic logic m_borrow(input int xa, input int xb);
        return xa < xb;
    endfunction

    function automatic logic m_ovf(input int xa, input int xb);
        int sa;
        int sb;
        int r;
        sa = (xa >= 512) ? xa - 1024 : xa;
        sb = (xb >= 512) ? xb - 1024 : xb;
        r  = sa - sb;
        return (r > 511) || (r < -512);
    endfunction

    // Accepts one operation and returns at the first falling edge where done is seen
    // (or after a bounded number of cycles). lat counts edges from acceptance to done.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output int lat, output int busy_cycles, output int overlap);
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        busy_cycles = 0;
        overlap = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) overlap++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checks++; if (diff !== '0)       begin errors++; $display("FAIL reset_diff got=%h want=000", diff); end
        checks++; if (borrow_out !== 0)  begin errors++; $display("FAIL reset_borrow got=%b want=0", borrow_out); end
        checks++; if (ovf !== 0)         begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        checks++; if (busy !== 0)        begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 0)        begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{10'h001, 10'h000, 10'h3FF, 10'h01F, 10'h200};
        logic [W-1:0] tb_ [5] = '{10'h000, 10'h001, 10'h001, 10'h3E0, 10'h001};
        int lat, bc, ov;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb_[i], lat, bc, ov);
            $display("directed %h - %h -> diff=%h borrow=%b ovf=%b lat=%0d busy=%0d",
                     ta[i], tb_[i], diff, borrow_out, ovf, lat, bc);
            checks++; if (lat !== 10) begin errors++; $display("FAIL dir_latency got=%0d want=10", lat); end
            checks++; if (bc !== 10)  begin errors++; $display("FAIL dir_busy_cycles got=%0d want=10", bc); end
            checks++; if (ov !== 0)   begin errors++; $display("FAIL dir_busy_done_overlap got=%0d want=0", ov); end
            checks++; if (diff !== m_diff(int'(ta[i]), int'(tb_[i])))
                begin errors++; $display("FAIL dir_diff got=%h want=%h", diff, m_diff(int'(ta[i]), int'(tb_[i]))); end
            checks++; if (borrow_out !== m_borrow(int'(ta[i]), int'(tb_[i])))
                begin errors++; $display("FAIL dir_borrow got=%b want=%b", borrow_out, m_borrow(int'(ta[i]), int'(tb_[i]))); end
            checks++; if (ovf !== m_ovf(int'(ta[i]), int'(tb_[i])))
                begin errors++; $display("FAIL dir_ovf got=%b want=%b", ovf, m_ovf(int'(ta[i]), int'(tb_[i]))); end
            @(negedge clk);
            checks++; if (done !== 0 || busy !== 0)
                begin errors++; $display("FAIL dir_done_pulse got done=%b busy=%b want 0 0", done, busy); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        int lat, bc, ov;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, lat, bc, ov);
            $display("random %h - %h -> diff=%h borrow=%b ovf=%b lat=%0d", ra, rb, diff, borrow_out, ovf, lat);
            checks++; if (lat !== 10 || ov !== 0)
                begin errors++; $display("FAIL rnd_timing got lat=%0d overlap=%0d want 10 0", lat, ov); end
            checks++; if ({diff, borrow_out, ovf} !== {m_diff(int'(ra), int'(rb)), m_borrow(int'(ra), int'(rb)), m_ovf(int'(ra), int'(rb))})
                begin errors++; $display("FAIL rnd_result got=%h/%b/%b want=%h/%b/%b", diff, borrow_out, ovf,
                      m_diff(int'(ra), int'(rb)), m_borrow(int'(ra), int'(rb)), m_ovf(int'(ra), int'(rb))); end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int pulses;
        int first_idx;
        logic [W-1:0] d_at;
        logic br_at;
        pulses = 0;
        first_idx = -1;
        d_at = 'x;
        br_at = 1'bx;
        @(negedge clk);
        a = 10'h01F;
        b = 10'h01F;
        start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = (n == 4);
            if (n == 4) begin
                a = 10'h3FF;
                b = 10'h000;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (done) begin
                pulses++;
                if (first_idx < 0) begin
                    first_idx = n - 1;
                    d_at = diff;
                    br_at = borrow_out;
                end
            end
        end
        start = 1'b0;
        $display("ignore_busy pulses=%0d first=%0d diff=%h borrow=%b", pulses, first_idx, d_at, br_at);
        checks++; if (pulses !== 1)      begin errors++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
        checks++; if (first_idx !== 10)  begin errors++; $display("FAIL ign_latency got=%0d want=10", first_idx); end
        checks++; if (d_at !== 10'h000)  begin errors++; $display("FAIL ign_diff got=%h want=000", d_at); end
        checks++; if (br_at !== 1'b0)    begin errors++; $display("FAIL ign_borrow got=%b want=0", br_at); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb;
        int lat, bc, ov;
        ra = W'($urandom);
        rb = W'($urandom);
        do_op(ra, rb, lat, bc, ov);
        a = 10'h3FF;
        b = 10'h000;
        start = 1'b1;
        checks++; if (lat !== 10 || diff !== m_diff(int'(ra), int'(rb)))
            begin errors++; $display("FAIL b2b_first got lat=%0d diff=%h want 10 %h", lat, diff, m_diff(int'(ra), int'(rb))); end
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        checks++; if (busy !== 1 || done !== 0)
            begin errors++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("back_to_back first=%h-%h second diff=%h borrow=%b lat=%0d", ra, rb, diff, borrow_out, lat);
        checks++; if (lat !== 10)      begin errors++; $display("FAIL b2b_latency got=%0d want=10", lat); end
        checks++; if (diff !== 10'h3FF || borrow_out !== 0 || ovf !== 0)
            begin errors++; $display("FAIL b2b_second got=%h/%b/%b want=3ff/0/0", diff, borrow_out, ovf); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bc, ov;
        int pulses;
        do_op(10'h005, 10'h001, lat, bc, ov);
        checks++; if (diff !== 10'h004) begin errors++; $display("FAIL ar_pre_diff got=%h want=004", diff); end
        @(negedge clk);
        a = 10'h123;
        b = 10'h245;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        $display("async_reset mid-op busy=%b done=%b diff=%h borrow=%b ovf=%b", busy, done, diff, borrow_out, ovf);
        checks++; if (busy !== 0 || done !== 0)
            begin errors++; $display("FAIL ar_ctrl got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (diff !== '0 || borrow_out !== 0 || ovf !== 0)
            begin errors++; $display("FAIL ar_outputs got=%h/%b/%b want=000/0/0", diff, borrow_out, ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ar_no_done got=%0d want=0", pulses); end
        do_op(10'h123, 10'h245, lat, bc, ov);
        $display("async_reset follow-up diff=%h borrow=%b ovf=%b lat=%0d", diff, borrow_out, ovf, lat);
        checks++; if (lat !== 10 || diff !== m_diff(32'h123, 32'h245) || borrow_out !== 1'b1)
            begin errors++; $display("FAIL ar_recover got lat=%0d diff=%h borrow=%b want 10 %h 1",
                  lat, diff, borrow_out, m_diff(32'h123, 32'h245)); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
